// File: rtl/sdram_rom_arbiter.sv
// Arbitrates the toggle-handshake SDRAM port between the ROM download
// byte stream (buffered in a small FIFO) and CPU ROM fetches (one-word cache).
module sdram_rom_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_overflow,
  input  logic              cpu_oe,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_hit,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  output logic              busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT1 = (PW+1)'(1);
  localparam logic [PW-1:0] PTR1 = PW'(1);

  typedef enum logic [1:0] {
    SYNC, IDLE, WR_WAIT, RD_WAIT
  } state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [1:0]        ds_q, ds_d;
  logic [15:0]       din_q, din_d;
  logic              ovf_q;
  logic              dla_q;
  logic              cvalid_q;
  logic [ADDR_W-2:0] ctag_q;
  logic [15:0]       cword_q;

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [7:0]        fd_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;

  logic empty, full, acked, pop, push, drop;
  logic dl_rise, tag_hit, issue_wr, issue_rd;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign acked     = (mem_ack == req_q);
  assign pop       = (state_q == WR_WAIT) && acked;
  assign push      = dl_wr && (!full || pop);
  assign drop      = dl_wr && full && !pop;
  assign dl_rise   = dl_active && !dla_q;
  assign tag_hit   = cvalid_q && (ctag_q == cpu_addr[ADDR_W-1:1]);
  assign head_addr = fa_q[rp_q];
  assign head_data = fd_q[rp_q];
  assign issue_wr  = (state_q == IDLE) && !empty;
  assign issue_rd  = (state_q == IDLE) && empty && !dl_active
                     && cpu_oe && !tag_hit;

  assign cpu_hit     = tag_hit && !dl_active;
  assign cpu_data    = cpu_addr[0] ? cword_q[15:8] : cword_q[7:0];
  assign busy        = (state_q != IDLE) || !empty;
  assign dl_overflow = ovf_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_ds      = ds_q;
  assign mem_din     = din_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    state_d = IDLE;
      IDLE: begin
        if (issue_wr)      state_d = WR_WAIT;
        else if (issue_rd) state_d = RD_WAIT;
      end
      WR_WAIT: if (acked) state_d = IDLE;
      RD_WAIT: if (acked) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // SYNC adopts the controller's ack level instead of assuming it reset too
  always_comb begin
    req_d  = req_q;
    we_d   = we_q;
    addr_d = addr_q;
    ds_d   = ds_q;
    din_d  = din_q;
    unique case (1'b1)
      state_q == SYNC: req_d = mem_ack;
      issue_wr: begin
        req_d  = ~req_q;
        we_d   = 1'b1;
        addr_d = head_addr[ADDR_W-1:1];
        ds_d   = {head_addr[0], ~head_addr[0]};
        din_d  = {head_data, head_data};
      end
      issue_rd: begin
        req_d  = ~req_q;
        we_d   = 1'b0;
        addr_d = cpu_addr[ADDR_W-1:1];
        ds_d   = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      ds_q     <= '0;
      din_q    <= '0;
      ovf_q    <= 1'b0;
      dla_q    <= 1'b0;
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      cword_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      req_q  <= req_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      ds_q   <= ds_d;
      din_q  <= din_d;
      dla_q  <= dl_active;
      if (dl_rise) ovf_q <= 1'b0;
      if (drop)    ovf_q <= 1'b1;
      if (push) wp_q <= wp_q + PTR1;
      if (pop)  rp_q <= rp_q + PTR1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT1;
        2'b01:   cnt_q <= cnt_q - CNT1;
        default: cnt_q <= cnt_q;
      endcase
      if ((state_q == RD_WAIT) && acked) begin
        cword_q  <= mem_dout;
        ctag_q   <= addr_q;
        cvalid_q <= 1'b1;
      end
      if (issue_wr || dl_rise) cvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fa_q[wp_q] <= dl_addr;
      fd_q[wp_q] <= dl_data;
    end
  end

endmodule

// File: doc/sdram_rom_arbiter.md
Name: sdram_rom_arbiter

Overview:
- Shares the single toggle-handshake SDRAM port between two requesters: the ROM download stream (byte writes from data_io) and CPU ROM fetches.
- Download bytes pass through a small FIFO. CPU reads are served from a one-word (16-bit) read cache.
- Sits between data_io / fpga core ROM port and the SDRAM controller in each arcade top level. It replaces the ad-hoc port1_req toggle logic.

Parameters:
- ADDR_W, 23, byte address width of the download and CPU address spaces; the word address is ADDR_W-1 bits.
- FIFO_DEPTH, 4, number of download byte entries buffered; power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  one-cycle byte write strobe.
- dl_addr  in  ADDR_W  download byte address.
- dl_data  in  8  download byte.
- dl_overflow  out  1  sticky: a dl_wr arrived while the FIFO was full.
- cpu_oe  in  1  CPU ROM read enable (level).
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_data  out  8  selected byte of the cached word.
- cpu_hit  out  1  cpu_data is valid for the current cpu_addr.
- mem_req  out  1  toggle request to SDRAM.
- mem_ack  in  1  toggle acknowledge; equals mem_req when the request is done.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W-1  word address.
- mem_ds  out  2  byte enables {upper, lower}.
- mem_din  out  16  write data.
- mem_dout  in  16  read data, valid when the ack toggles.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_ds=0, mem_din=0, dl_overflow=0, cache invalid, FIFO empty, state=SYNC.
- Outputs on reset: cpu_hit=0, busy=1.
- State machine: SYNC, IDLE, WR_WAIT, RD_WAIT.
- SYNC: the first clock after reset release sets mem_req<=mem_ack, which aligns the toggle pair without assuming the controller was also reset. Next state is IDLE.
- FIFO push: dl_wr=1 and the FIFO is not full pushes {dl_addr, dl_data}.
  - dl_wr while full is dropped and sets dl_overflow.
  - dl_overflow clears only on reset or on a dl_active rising edge.
  - Push and pop in the same cycle are allowed when full: the occupancy is unchanged and the write is not dropped.
- IDLE, write issue (priority 1): FIFO non-empty. Drive the head entry:
  - mem_we=1, mem_addr=addr[ADDR_W-1:1], mem_ds={addr[0], ~addr[0]}, mem_din={data, data}.
  - Toggle mem_req. Invalidate the cache. Go to WR_WAIT.
- IDLE, read issue (priority 2): FIFO empty, dl_active=0, cpu_oe=1, and a cache miss. Drive:
  - mem_we=0, mem_addr=cpu_addr[ADDR_W-1:1], mem_ds=2'b11.
  - Toggle mem_req. Go to RD_WAIT.
- WR_WAIT: when mem_ack==mem_req, pop the FIFO and go to IDLE. A new issue is possible on the following cycle, so the minimum spacing is 2 clocks per request.
- RD_WAIT: when mem_ack==mem_req, set cache_word<=mem_dout, cache_tag<=the issued word address, cache_valid<=1. Go to IDLE.
  - cpu_addr changing during RD_WAIT does not abort the read; the miss is reissued afterwards.
- cpu_hit is combinational: cache_valid & (cache_tag==cpu_addr[ADDR_W-1:1]) & ~dl_active.
- cpu_data is combinational: cpu_addr[0] ? cache_word[15:8] : cache_word[7:0]. Its value is don't-care when cpu_hit=0.
- Read latency: the miss is detected in cycle 0, mem_req toggles at the end of cycle 0, and cpu_hit rises the cycle after the ack is seen.
- dl_active rising edge invalidates the cache.
- CPU reads are never issued while dl_active=1. FIFO entries remaining after dl_active falls are still written before any read.
- Mem outputs hold their values between requests.
- Reset mid-operation: state returns to SYNC, the FIFO is emptied, and the outstanding SDRAM request is abandoned. SYNC realigns the toggles.

Test Plan:
- Reset release with mem_ack held at 1 -> after 1 clock mem_req=1, no request issued, busy=0 once idle.
- dl_active=1, writes byte 0xA5 to addr 0x000001, then 0x3C to 0x000002 -> requests issued in order:
  - first: mem_addr=0, mem_ds=2'b10, mem_din=0xA5A5, mem_we=1;
  - second: mem_addr=1, mem_ds=2'b01, mem_din=0x3C3C.
- Ack held off, 5 back-to-back dl_wr with FIFO_DEPTH=4 -> first 4 buffered. The 5th is dropped only if no pop coincides; in that case dl_overflow=1. All buffered bytes are eventually written.
- dl_active=0, cpu_oe=1, cpu_addr=0x0041, mem_dout=0x1234 at ack -> one read with mem_addr=0x20, mem_ds=2'b11; then cpu_hit=1, cpu_data=0x12.
  - Then cpu_addr=0x0040 -> cpu_hit=1, cpu_data=0x34, and no new request.
- Cache valid for tag 0x20, then a download write is issued -> cpu_hit=0. A later read of 0x0040 issues a new SDRAM read.
- reset asserted during RD_WAIT -> all outputs at reset values immediately (asynchronous). After release, SYNC realigns and a pending cpu_oe miss is reissued.
